// File: rtl/cdc_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Package     : cdc_pkg
// Description : Shared constants and types for both ends of the 4-phase
//               req/ack handshake (fast-side sender and slow-side receiver).
// Revision    : 1.0 - initial release
// ============================================================================
package cdc_pkg;

  // Explicit 2-bit state encodings; the sender reuses the same values.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_VALID = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;

  // Default synchroniser depth for either direction of the handshake.
  localparam int unsigned SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_VALID = ST_VALID,
    S_ACK   = ST_ACK
  } hs_state_e;

endpackage : cdc_pkg
`default_nettype wire

// File: rtl/cdc_sync_bit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : cdc_sync_bit
// Description : Multi-flop synchroniser for a single asynchronous level.
//               Output q is the last stage of the chain.
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // Shift the asynchronous input one stage deeper each clock.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  // Chain register; cleared asynchronously so no stale request survives reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule : cdc_sync_bit
`default_nettype wire

// File: rtl/cdc_hs_rx_slow.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : cdc_hs_rx_slow
// Description : Slow-domain receiver of a 4-phase req/ack handshake. Captures
//               the sender-held payload once per request, offers it on a
//               valid/ready interface, then returns ack_s.
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_hs_rx_slow
  import cdc_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W       = 16
) (
  input  logic              clk_s,
  input  logic              rst_n,
  input  logic              req_f,
  input  logic [DATA_W-1:0] data_f,
  output logic              ack_s,
  output logic              valid_s,
  input  logic              ready_s,
  output logic [DATA_W-1:0] data_s,
  output logic [CNT_W-1:0]  rx_cnt,
  output logic              err_s
);

  logic              req_sync;
  hs_state_e         state_q,  state_d;
  logic              ack_q,    ack_d;
  logic              valid_q,  valid_d;
  logic [DATA_W-1:0] data_q,   data_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic              err_q,    err_d;

  // req_f is only ever observed through this synchroniser.
  cdc_sync_bit #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk   (clk_s),
    .rst_n (rst_n),
    .d     (req_f),
    .q     (req_sync)
  );

  // Handshake FSM: next state and next values of every registered output.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        // data_f is stable here: req_sync lags req_f by the chain depth.
        if (req_sync) begin
          data_d  = data_f;
          valid_d = 1'b1;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        // Sender dropped req before ack: flag it but finish the transfer.
        if (!req_sync) err_d = 1'b1;
        if (ready_s) begin
          valid_d = 1'b0;
          ack_d   = 1'b1;
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (!req_sync) begin
          ack_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        // Unreachable encoding: recover to a clean idle.
        ack_d   = 1'b0;
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers, all dropped by the asynchronous reset.
  always_ff @(posedge clk_s or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign ack_s   = ack_q;
  assign valid_s = valid_q;
  assign data_s  = data_q;
  assign rx_cnt  = cnt_q;
  assign err_s   = err_q;

endmodule : cdc_hs_rx_slow
`default_nettype wire

// File: tb/tb_cdc_hs_rx_slow.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_cdc_hs_rx_slow
// Description : Self-checking bench for cdc_hs_rx_slow. A fast-side sender
//               model queues expected payloads; a monitor pops and compares
//               them on every accepted valid/ready cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdc_hs_rx_slow;

  localparam int DATA_W = 8;
  localparam int SS     = 2;
  localparam int CNT_W  = 4;
  localparam int CMOD   = 1 << CNT_W;

  logic              clk_s   = 1'b0;
  logic              rst_n   = 1'b0;
  logic              req_f   = 1'b0;
  logic [DATA_W-1:0] data_f  = '0;
  logic              ready_s = 1'b0;
  logic              ack_s;
  logic              valid_s;
  logic [DATA_W-1:0] data_s;
  logic [CNT_W-1:0]  rx_cnt;
  logic              err_s;

  cdc_hs_rx_slow #(
    .DATA_W      (DATA_W),
    .SYNC_STAGES (SS),
    .CNT_W       (CNT_W)
  ) dut (
    .clk_s   (clk_s),
    .rst_n   (rst_n),
    .req_f   (req_f),
    .data_f  (data_f),
    .ack_s   (ack_s),
    .valid_s (valid_s),
    .ready_s (ready_s),
    .data_s  (data_s),
    .rx_cnt  (rx_cnt),
    .err_s   (err_s)
  );

  always #50 clk_s = ~clk_s;

  int checks = 0;
  int fails  = 0;
  logic [DATA_W-1:0] exp_q[$];
  int  exp_cnt   = 0;   // accepted transfers since reset, modulo 2^CNT_W
  int  sent      = 0;   // transfers issued since reset
  bit  rnd_ready = 1'b0;

  // Monitor history
  logic              m_pv   = 1'b0;
  logic              m_pr   = 1'b0;
  logic              m_pend = 1'b0;
  logic [DATA_W-1:0] m_pd   = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic level_of(input int which);
    return (which == 0) ? valid_s : ack_s;
  endfunction

  // Count posedges until valid_s (which=0) or ack_s (which=1) reaches lvl.
  task automatic wait_level(input int which, input logic lvl, input int budget, output int n);
    n = 0;
    while (n < budget) begin
      @(posedge clk_s); #1;
      n++;
      if (level_of(which) == lvl) return;
    end
    checks++;
    fails++;
    $display("FAIL timeout %s: still %b, expected %b after %0d cycles",
             (which == 0) ? "valid_s" : "ack_s", level_of(which), lvl, budget);
  endtask

  // One complete 4-phase transfer from the fast side.
  task automatic send(input logic [DATA_W-1:0] d, input int pre_gap_ns);
    int n;
    wait_level(1, 1'b0, 50, n);
    #(pre_gap_ns);
    data_f = d;
    #35;
    req_f = 1'b1;
    exp_q.push_back(d);
    sent++;
    wait_level(1, 1'b1, 400, n);
    #35;
    req_f = 1'b0;
  endtask

  // Random backpressure driver
  initial begin
    forever begin
      @(posedge clk_s); #7;
      if (rnd_ready) ready_s = 1'($urandom_range(0, 1));
    end
  end

  // Scoreboard monitor, sampling mid-cycle.
  initial begin
    forever begin
      @(negedge clk_s);
      if (!rst_n) begin
        m_pv = 1'b0; m_pr = 1'b0; m_pend = 1'b0;
        continue;
      end
      check("ack_valid_exclusive", {31'd0, ack_s & valid_s}, 32'd0);
      if (m_pend) begin
        check("ack_after_accept", {30'd0, ack_s, valid_s}, 32'd2);
        check("rx_cnt", {28'd0, rx_cnt}, exp_cnt);
        m_pend = 1'b0;
      end
      if (m_pv && !m_pr) begin
        check("valid_held", {31'd0, valid_s}, 32'd1);
        check("data_held", {24'd0, data_s}, {24'd0, m_pd});
      end
      if (!m_pv && valid_s)
        check("capture_eq_data_f", {24'd0, data_s}, {24'd0, data_f});
      if (valid_s && ready_s) begin
        if (exp_q.size() == 0) begin
          check("unexpected_accept_qsize", 32'd0, 32'd1);
        end else begin
          check("data_s", {24'd0, data_s}, {24'd0, exp_q.pop_front()});
        end
        exp_cnt = (exp_cnt + 1) % CMOD;
        m_pend  = 1'b1;
      end
      m_pv = valid_s;
      m_pr = ready_s;
      m_pd = data_s;
    end
  end

  // Time bound on the whole run
  initial begin
    #3ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    int n;
    #1;
    check("reset_outputs", {16'd0, ack_s, valid_s, err_s, rx_cnt, data_s}, 32'd0);
    repeat (3) @(posedge clk_s);
    #20 rst_n = 1'b1;
    repeat (2) @(posedge clk_s);

    // 1: single transfer with latency checks
    ready_s = 1'b1;
    @(posedge clk_s); #1;
    #35 data_f = 8'hA5;
    #35 req_f  = 1'b1;
    exp_q.push_back(8'hA5);
    sent++;
    wait_level(0, 1'b1, 20, n);
    check("req_to_valid_edges", n, SS + 1);
    wait_level(1, 1'b1, 20, n);
    #35 req_f = 1'b0;
    wait_level(1, 1'b0, 20, n);
    check("ack_fall_in_2_3_edges", {31'd0, (n >= 2 && n <= SS + 1)}, 32'd1);
    check("single_rx_cnt", {28'd0, rx_cnt}, 32'd1);
    check("single_err", {31'd0, err_s}, 32'd0);

    // 2: backpressure
    ready_s = 1'b0;
    @(posedge clk_s); #1;
    #35 data_f = 8'h3C;
    #35 req_f  = 1'b1;
    exp_q.push_back(8'h3C);
    sent++;
    wait_level(0, 1'b1, 20, n);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_s); #1;
      check("bp_hold", {22'd0, valid_s, ack_s, data_s}, {22'd0, 1'b1, 1'b0, 8'h3C});
    end
    ready_s = 1'b1;
    wait_level(1, 1'b1, 20, n);
    #35 req_f = 1'b0;
    wait_level(1, 1'b0, 20, n);
    check("bp_rx_cnt", {28'd0, rx_cnt}, sent % CMOD);

    // 3: back-to-back ordered payloads
    for (int i = 0; i < 20; i++) send(8'(i), 0);
    wait_level(1, 1'b0, 20, n);
    check("b2b_rx_cnt", {28'd0, rx_cnt}, sent % CMOD);
    check("b2b_err", {31'd0, err_s}, 32'd0);

    // Random payloads, gaps and backpressure
    rnd_ready = 1'b1;
    for (int i = 0; i < 12; i++) send(8'($urandom), int'($urandom_range(1, 250)));
    wait_level(1, 1'b0, 20, n);
    rnd_ready = 1'b0;
    @(posedge clk_s); #1;
    check("rand_rx_cnt", {28'd0, rx_cnt}, sent % CMOD);
    check("rand_err", {31'd0, err_s}, 32'd0);

    // 4: request withdrawn while data is still pending
    ready_s = 1'b0;
    #35 data_f = 8'h5A;
    #35 req_f  = 1'b1;
    exp_q.push_back(8'h5A);
    sent++;
    wait_level(0, 1'b1, 20, n);
    #35 req_f = 1'b0;
    repeat (4) begin @(posedge clk_s); #1; end
    check("early_drop_err", {31'd0, err_s}, 32'd1);
    ready_s = 1'b1;
    wait_level(1, 1'b1, 20, n);
    wait_level(1, 1'b0, 20, n);
    check("err_sticky", {31'd0, err_s}, 32'd1);

    // 5: reset while VALID with req still high
    ready_s = 1'b0;
    @(posedge clk_s); #1;
    #35 data_f = 8'h77;
    #35 req_f  = 1'b1;
    exp_q.push_back(8'h77);
    wait_level(0, 1'b1, 20, n);
    @(posedge clk_s);
    #30 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {16'd0, ack_s, valid_s, err_s, rx_cnt, data_s}, 32'd0);
    exp_q.delete();
    exp_cnt = 0;
    exp_q.push_back(8'h77);
    sent = 1;
    @(negedge clk_s);
    #5 rst_n = 1'b1;
    wait_level(0, 1'b1, 20, n);
    check("recapture_edges", n, SS + 1);
    ready_s = 1'b1;
    wait_level(1, 1'b1, 20, n);
    #35 req_f = 1'b0;
    wait_level(1, 1'b0, 20, n);
    check("post_reset_rx_cnt", {28'd0, rx_cnt}, 32'd1);

    // 6: counter wrap
    for (int i = 0; i < 17; i++) send(8'(8'h80 + i), 0);
    wait_level(1, 1'b0, 20, n);
    check("wrap_rx_cnt", {28'd0, rx_cnt}, sent % CMOD);

    repeat (4) @(posedge clk_s);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule : tb_cdc_hs_rx_slow
`default_nettype wire
